// File: rtl/fetch_pc_gen_if.sv
// fetch_pc_gen_if: fetch request/response bundle between PC generator and icache side
interface fetch_pc_gen_if #(parameter int EPOCH_W = 2);
  logic                 stall;
  logic                 flush;
  logic [31:0]          flush_pc;
  logic                 bpu_taken;
  logic [31:0]          bpu_target;
  logic                 req_valid;
  logic                 req_ready;
  logic [1:0][31:0]     req_pc;
  logic [1:0]           req_en;
  logic [EPOCH_W-1:0]   req_epoch;
  logic                 req_adef;
  logic                 resp_valid;
  logic [EPOCH_W-1:0]   resp_epoch;
  logic                 resp_keep;
  modport master (
    input  stall, flush, flush_pc, bpu_taken, bpu_target, req_ready, resp_valid, resp_epoch,
    output req_valid, req_pc, req_en, req_epoch, req_adef, resp_keep
  );
  modport slave (
    output stall, flush, flush_pc, bpu_taken, bpu_target, req_ready, resp_valid, resp_epoch,
    input  req_valid, req_pc, req_en, req_epoch, req_adef, resp_keep
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: dual-slot fetch PC generator with redirect priority, epoch tagging and outstanding limit
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
  parameter int          LINE_BYTES      = 16,
  parameter int          MAX_OUTSTANDING = 4,
  parameter int          EPOCH_W         = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_pc_gen_if.master bus
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  typedef enum logic {RUN, HALT} state_t;
  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic [OW-1:0]      outst_q, outst_d;
  logic               adef, valid, en1, fire;
  logic [31:0]        line_off;
  always_comb begin
    adef     = pc_q[1:0] != 2'b00;
    line_off = pc_q & 32'(LINE_BYTES - 1);
    valid    = !rst && state_q == RUN && !bus.stall && !bus.flush && outst_q < OW'(MAX_OUTSTANDING);
    en1      = valid && !adef && (line_off + 32'd4 < 32'(LINE_BYTES));
    fire     = valid && bus.req_ready;
    pc_d     = bus.flush ? bus.flush_pc :
               (fire && bus.bpu_taken) ? bus.bpu_target :
               fire ? pc_q + (en1 ? 32'd8 : 32'd4) : pc_q;
    epoch_d  = bus.flush ? epoch_q + EPOCH_W'(1) : epoch_q;
    state_d  = bus.flush ? RUN : (fire && adef) ? HALT : state_q;
    outst_d  = outst_q + OW'(fire) - OW'(bus.resp_valid);
  end
  assign bus.req_valid = valid;
  assign bus.req_pc    = {pc_q + 32'd4, pc_q};
  assign bus.req_en    = {en1, valid};
  assign bus.req_epoch = epoch_q;
  assign bus.req_adef  = valid && adef;
  assign bus.resp_keep = !rst && bus.resp_valid && bus.resp_epoch == epoch_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      epoch_q <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      outst_q <= outst_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) assert (!(bus.resp_valid && outst_q == '0));
  end
endmodule
